pwm_multi_generator: RTL and testbench

- Parametrised multi-channel PWM generator for the frequency-scaling subsystem.
- A shared prescaler and period counter drive CHANNELS independent comparators.
- Each channel has a double-buffered (shadow/active) duty register, so duty updates never glitch mid-period.
- Supports edge-aligned and centre-aligned modes and exports a period clock plus a period-start strobe to downstream logic.

---
 rtl/pwm_multi_generator.sv | 142 ++++++++++++++
 tb/tb_pwm_multi_generator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_generator.sv
// pwm_multi_generator
// Multi-channel PWM generator. One prescaler and one period counter are
// shared by CHANNELS comparators. Each channel has a shadow duty register
// that software writes at any time. An active duty register copies the
// shadow only at a period boundary, so a running period is never cut short.
// The counter runs edge-aligned (sawtooth) or centre-aligned (triangle).
// A period clock and a period-start strobe go to downstream logic.

module pwm_multi_generator #(
  parameter int CHANNELS = 4,
  parameter int RES      = 4,
  parameter int PRESCALE = 1
) (
  input  logic                    clk_3125KHz,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [CHANNELS-1:0]     duty_load,
  input  logic [CHANNELS*RES-1:0] duty_in,
  output logic [CHANNELS-1:0]     pwm_out,
  output logic                    period_clk,
  output logic                    period_start
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [RES-1:0]   CNT_MAX  = '1;
  localparam logic [RES-1:0]   CNT_ONE  = RES'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [RES-1:0]   cnt;
  logic [RES-1:0]   cnt_next;
  dir_t             dir;
  dir_t             dir_next;
  logic             mode_act;
  logic             boundary;
  logic             boundary_q;
  logic [RES-1:0]   shadow [CHANNELS];
  logic [RES-1:0]   active [CHANNELS];

  assign tick     = enable && (pre == PRE_LAST);
  assign boundary = tick && (cnt_next == '0);

  // Prescaler: divides the system clock down to counter ticks, parked at 0 while disabled
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (!enable || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_ONE;
    end
  end

  // Next counter value and direction; direction flips to down when the count reaches
  // its top so period_clk splits a centre-aligned period into two equal halves
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    if (!mode_act) begin
      cnt_next = cnt + CNT_ONE;
      dir_next = DIR_UP;
    end else if (dir == DIR_UP) begin
      cnt_next = cnt + CNT_ONE;
      if (cnt_next == CNT_MAX) begin
        dir_next = DIR_DOWN;
      end
    end else begin
      cnt_next = cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        dir_next = DIR_UP;
      end
    end
  end

  // Counter state: advance on ticks, latch the mode only when a new period begins
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      dir        <= DIR_UP;
      mode_act   <= 1'b0;
      boundary_q <= 1'b0;
    end else if (!enable) begin
      cnt        <= '0;
      dir        <= DIR_UP;
      boundary_q <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= cnt_next;
        dir <= dir_next;
      end
      if (boundary) begin
        mode_act <= mode;
      end
      boundary_q <= boundary;
    end
  end

  // Duty double buffer: the shadow takes writes at any time; the active copy
  // takes the shadow at a boundary, or on every clock while disabled
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!enable || boundary) begin
          active[i] <= shadow[i];
        end
        if (duty_load[i]) begin
          shadow[i] <= duty_in[i*RES +: RES];
        end
      end
    end
  end

  // Registered outputs; period_start follows the boundary by one clock so that it lines up
  // with the first pwm_out sample taken from cnt == 0
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= '0;
      period_clk   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= enable && (cnt < active[i]);
      end
      period_clk   <= enable && (mode_act ? (dir == DIR_UP) : ~cnt[RES-1]);
      period_start <= enable && boundary_q;
    end
  end

endmodule

// File: tb/tb_pwm_multi_generator.sv
// tb_pwm_multi_generator
// Drives two instances (PRESCALE=1 and PRESCALE=4) with the same inputs.
// Each instance is compared every clock against a model that tracks its
// position inside the period, and the counter value is derived from that
// position. Window counts of high cycles are compared with hand-derived figures.

module tb_pwm_multi_generator;

  localparam int CH       = 4;
  localparam int RES      = 4;
  localparam int MAXC     = 15;
  localparam int EDGE_LEN = 16;
  localparam int PRE_A    = 1;
  localparam int PRE_B    = 4;

  logic        clk_3125KHz = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        mode;
  logic [3:0]  duty_load;
  logic [15:0] duty_in;
  logic [3:0]  pwm_a, pwm_b;
  logic        pclk_a, pclk_b, ps_a, ps_b;

  int totalChecks = 0;
  int passChecks  = 0;
  int cycle       = 0;

  // Model state per instance
  int   posM    [2];
  int   subM    [2];
  bit   modeM   [2];
  bit   startM  [2];
  int   shadowM [2][4];
  int   activeM [2][4];
  logic [3:0] expPwm  [2];
  logic       expPclk [2];
  logic       expPs   [2];

  // Window statistics taken from the DUT outputs
  int winHi   [2][4];
  int winPclk [2];
  int winPs   [2];

  pwm_multi_generator #(.CHANNELS(CH), .RES(RES), .PRESCALE(PRE_A)) dut_a (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .duty_load   (duty_load),
    .duty_in     (duty_in),
    .pwm_out     (pwm_a),
    .period_clk  (pclk_a),
    .period_start(ps_a)
  );

  pwm_multi_generator #(.CHANNELS(CH), .RES(RES), .PRESCALE(PRE_B)) dut_b (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .duty_load   (duty_load),
    .duty_in     (duty_in),
    .pwm_out     (pwm_b),
    .period_clk  (pclk_b),
    .period_start(ps_b)
  );

  // Free-running system clock
  always #5 clk_3125KHz = ~clk_3125KHz;

  // Counter value at a given tick position in the period
  function automatic int cntOf(int pos, bit m);
    if (!m) return pos;
    return (pos <= MAXC) ? pos : (2 * MAXC - pos);
  endfunction

  function automatic int periodLen(bit m);
    return m ? (2 * MAXC) : EDGE_LEN;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      posM[k]    = 0;
      subM[k]    = 0;
      modeM[k]   = 1'b0;
      startM[k]  = 1'b0;
      expPwm[k]  = '0;
      expPclk[k] = 1'b0;
      expPs[k]   = 1'b0;
      for (int i = 0; i < CH; i++) begin
        shadowM[k][i] = 0;
        activeM[k][i] = 0;
      end
    end
  endtask

  // One clock edge of the model: outputs come from the pre-edge state, then the state advances
  task automatic modelEdge(int k, int pre, bit en, bit md, logic [3:0] ld, logic [15:0] din);
    int c;
    c = cntOf(posM[k], modeM[k]);
    for (int i = 0; i < CH; i++) expPwm[k][i] = en && (c < activeM[k][i]);
    expPclk[k] = en && (modeM[k] ? (posM[k] < MAXC) : (c < EDGE_LEN / 2));
    expPs[k]   = en && startM[k];
    startM[k]  = 1'b0;
    if (!en) begin
      posM[k] = 0;
      subM[k] = 0;
      for (int i = 0; i < CH; i++) activeM[k][i] = shadowM[k][i];
    end else if (subM[k] == pre - 1) begin
      subM[k] = 0;
      posM[k] = posM[k] + 1;
      if (posM[k] == periodLen(modeM[k])) begin
        posM[k]   = 0;
        startM[k] = 1'b1;
        modeM[k]  = md;
        for (int i = 0; i < CH; i++) activeM[k][i] = shadowM[k][i];
      end
    end else begin
      subM[k] = subM[k] + 1;
    end
    for (int i = 0; i < CH; i++) begin
      if (ld[i]) shadowM[k][i] = int'(din[i*4 +: 4]);
    end
  endtask

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) begin
      passChecks++;
    end else begin
      $error("[TB] FAIL %s (cycle %0d): observed %0d expected %0d", tag, cycle, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("pwm_a",  32'(pwm_a),  32'(expPwm[0]));
    checkVal("pclk_a", 32'(pclk_a), 32'(expPclk[0]));
    checkVal("ps_a",   32'(ps_a),   32'(expPs[0]));
    checkVal("pwm_b",  32'(pwm_b),  32'(expPwm[1]));
    checkVal("pclk_b", 32'(pclk_b), 32'(expPclk[1]));
    checkVal("ps_b",   32'(ps_b),   32'(expPs[1]));
  endtask

  task automatic clearWindow();
    for (int k = 0; k < 2; k++) begin
      winPclk[k] = 0;
      winPs[k]   = 0;
      for (int i = 0; i < CH; i++) winHi[k][i] = 0;
    end
  endtask

  task automatic applyStimulus(bit en, bit md, logic [3:0] ld, logic [15:0] din);
    enable    = en;
    mode      = md;
    duty_load = ld;
    duty_in   = din;
  endtask

  task automatic runCycle();
    @(posedge clk_3125KHz);
    cycle++;
    modelEdge(0, PRE_A, enable, mode, duty_load, duty_in);
    modelEdge(1, PRE_B, enable, mode, duty_load, duty_in);
    #1;
    checkOutput();
    for (int i = 0; i < CH; i++) begin
      winHi[0][i] += int'(pwm_a[i]);
      winHi[1][i] += int'(pwm_b[i]);
    end
    winPclk[0] += int'(pclk_a);
    winPclk[1] += int'(pclk_b);
    winPs[0]   += int'(ps_a);
    winPs[1]   += int'(ps_b);
  endtask

  task automatic runCycles(int n);
    for (int j = 0; j < n; j++) runCycle();
  endtask

  task automatic loadDuty(int ch, logic [3:0] val);
    logic [3:0]  ld;
    logic [15:0] d;
    ld     = '0;
    ld[ch] = 1'b1;
    d      = duty_in;
    d[ch*4 +: 4] = val;
    applyStimulus(enable, mode, ld, d);
    runCycle();
    applyStimulus(enable, mode, 4'b0000, d);
  endtask

  // Advances until instance A's model is at the given period position, within a cycle budget
  task automatic waitPos(int target, int budget);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      if (posM[0] == target) found = 1'b1;
      else runCycle();
    end
    if (!found && posM[0] != target) begin
      totalChecks++;
      $error("[TB] FAIL waitPos timeout: observed position %0d expected %0d", posM[0], target);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 4'b0000, 16'h0000);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    modelReset();
    $display("[TB] reset asserted");
    checkOutput();
    repeat (2) @(posedge clk_3125KHz);
    #1 rst_n = 1'b1;

    // Basic edge-aligned operation with ch0 duty 7
    applyStimulus(1'b1, 1'b0, 4'b0000, 16'h0000);
    loadDuty(0, 4'd7);
    runCycles(100);
    clearWindow();
    runCycles(64);
    checkVal("win_a_ch0_high", 32'(winHi[0][0]), 32'd28);
    checkVal("win_a_pstart",   32'(winPs[0]),    32'd4);
    checkVal("win_a_pclk",     32'(winPclk[0]),  32'd32);
    checkVal("win_b_ch0_high", 32'(winHi[1][0]), 32'd28);
    checkVal("win_b_pstart",   32'(winPs[1]),    32'd1);
    checkVal("win_b_pclk",     32'(winPclk[1]),  32'd32);
    checkVal("win_a_ch3_high", 32'(winHi[0][3]), 32'd0);

    // Duty extremes
    loadDuty(1, 4'd0);
    loadDuty(2, 4'd15);
    runCycles(70);
    clearWindow();
    runCycles(64);
    checkVal("win_a_ch1_high", 32'(winHi[0][1]), 32'd0);
    checkVal("win_a_ch2_high", 32'(winHi[0][2]), 32'd60);
    checkVal("win_b_ch2_high", 32'(winHi[1][2]), 32'd60);
    checkVal("win_b_ch3_high", 32'(winHi[1][3]), 32'd0);

    // Double buffering: mid-period load, then a load on the boundary edge itself
    waitPos(5, 40);
    loadDuty(0, 4'd3);
    waitPos(15, 40);
    loadDuty(0, 4'd12);
    runCycles(40);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  ld;
      logic [15:0] d;
      bit          en;
      bit          md;
      en = ($urandom_range(0, 39) != 0);
      md = ($urandom_range(0, 49) == 0) ? ~mode : mode;
      for (int i = 0; i < CH; i++) ld[i] = ($urandom_range(0, 7) == 0);
      d = 16'($urandom);
      applyStimulus(en, md, ld, d);
      runCycle();
    end

    // Centre-aligned mode with ch0 duty 4
    applyStimulus(1'b1, 1'b1, 4'b0000, duty_in);
    loadDuty(0, 4'd4);
    runCycles(200);
    clearWindow();
    runCycles(120);
    checkVal("win_a_centre_ch0", 32'(winHi[0][0]), 32'd28);
    checkVal("win_a_centre_pclk", 32'(winPclk[0]), 32'd60);
    checkVal("win_a_centre_ps",  32'(winPs[0]),    32'd4);
    checkVal("win_b_centre_ch0", 32'(winHi[1][0]), 32'd28);
    checkVal("win_b_centre_ps",  32'(winPs[1]),    32'd1);

    // Enable drop at cnt=9 and restart
    applyStimulus(1'b1, 1'b0, 4'b0000, duty_in);
    runCycles(150);
    waitPos(9, 60);
    applyStimulus(1'b0, 1'b0, 4'b0000, duty_in);
    runCycle();
    checkVal("disabled_pwm_a", 32'(pwm_a), 32'd0);
    runCycles(3);
    applyStimulus(1'b1, 1'b0, 4'b0000, duty_in);
    runCycles(40);

    // Asynchronous reset pulse between edges
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0000, duty_in);
    runCycles(80);
    checkVal("post_reset_pwm_b", 32'(pwm_b), 32'd0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
